// File: rtl/mux_cfg_loader_pkg.sv
// Shared definitions for the console-mux configuration loader: command opcodes,
// loader FSM states and a small header-decoding helper.
package mux_cfg_loader_pkg;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_SET_SEL = 4'h1;
  localparam logic [3:0] OP_SET_EN  = 4'h2;
  localparam logic [3:0] OP_COMMIT  = 4'h3;
  localparam logic [3:0] OP_CLR_ERR = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_APPLY
  } state_t;

  // Headers of these opcodes are followed by exactly one data byte.
  function automatic logic needs_data(input logic [3:0] op);
    return (op == OP_SET_SEL) || (op == OP_SET_EN);
  endfunction

endpackage

// File: rtl/mux_cfg_loader_if.sv
// Byte-stream command channel feeding the loader (UART RX or host link side).
interface mux_cfg_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/mux_cfg_timeout.sv
// Loadable down-counter bounding the wait between a header and its data byte.
// expired goes high once the loaded count has been fully consumed.
module mux_cfg_timeout #(
  parameter  int TIMEOUT_CYCLES = 1000,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(TIMEOUT_CYCLES - 1);
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/mux_cfg_loader.sv
// Parses command bytes into shadow selector/enable registers and copies them
// atomically to the active mux controls on COMMIT, so partial configs never show.
module mux_cfg_loader
  import mux_cfg_loader_pkg::*;
#(
  parameter  int INPUT_COUNT    = 4,
  parameter  int OUTPUT_COUNT   = 4,
  parameter  int TIMEOUT_CYCLES = 1000,
  localparam int SEL_W          = $clog2(INPUT_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  mux_cfg_loader_if.slave               rx,
  output logic [OUTPUT_COUNT*SEL_W-1:0] selectors,
  output logic [OUTPUT_COUNT-1:0]       enabled_out,
  output logic                          cfg_error,
  output logic                          busy
);

  state_t state, state_nxt;

  logic [3:0] op_q, idx_q;
  logic [OUTPUT_COUNT-1:0][SEL_W-1:0] shadow_sel;
  logic [OUTPUT_COUNT-1:0]            shadow_en;

  logic accept, latch_hdr, sel_we, en_we, err_set, err_clr, commit;
  logic tmo_load, tmo_en, tmo_expired;
  logic [3:0] hdr_op;

  assign accept = rx.rx_valid && rx.rx_ready;
  assign hdr_op = rx.rx_data[7:4];

  mux_cfg_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (tmo_load),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rx.rx_ready = (state != ST_APPLY);
    busy        = (state != ST_IDLE);
    latch_hdr   = 1'b0;
    sel_we      = 1'b0;
    en_we       = 1'b0;
    err_set     = 1'b0;
    err_clr     = 1'b0;
    commit      = 1'b0;
    tmo_load    = 1'b0;
    tmo_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (needs_data(hdr_op)) begin
            state_nxt = ST_WAIT_DATA;
            latch_hdr = 1'b1;
            tmo_load  = 1'b1;
          end else if (hdr_op == OP_COMMIT) begin
            state_nxt = ST_APPLY;
          end else if (hdr_op == OP_CLR_ERR) begin
            err_clr = 1'b1;
          end else if (hdr_op != OP_NOP) begin
            err_set = 1'b1;
          end
        end
      end
      ST_WAIT_DATA: begin
        if (accept) begin
          state_nxt = ST_IDLE;
          if (op_q == OP_SET_EN) begin
            en_we = 1'b1;
          end else if ((32'(idx_q) < 32'(OUTPUT_COUNT)) &&
                       (32'(rx.rx_data) < 32'(INPUT_COUNT))) begin
            sel_we = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end else if (tmo_expired) begin
          // Abandon the half-received command; the next byte is a fresh header.
          state_nxt = ST_IDLE;
          err_set   = 1'b1;
        end else begin
          tmo_en = 1'b1;
        end
      end
      ST_APPLY: begin
        commit    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= OP_NOP;
      idx_q       <= '0;
      shadow_sel  <= '0;
      shadow_en   <= '0;
      selectors   <= '0;
      enabled_out <= '0;
      cfg_error   <= 1'b0;
    end else begin
      if (latch_hdr) begin
        op_q  <= hdr_op;
        idx_q <= rx.rx_data[3:0];
      end
      for (int k = 0; k < OUTPUT_COUNT; k++) begin
        if (sel_we && (32'(idx_q) == 32'(k))) begin
          shadow_sel[k] <= rx.rx_data[SEL_W-1:0];
        end
      end
      if (en_we) begin
        shadow_en <= rx.rx_data[OUTPUT_COUNT-1:0];
      end
      if (commit) begin
        selectors   <= shadow_sel;
        enabled_out <= shadow_en;
      end
      // A new error outranks a clear landing in the same cycle.
      if (err_set) begin
        cfg_error <= 1'b1;
      end else if (err_clr) begin
        cfg_error <= 1'b0;
      end
    end
  end

endmodule
